bf_uart_bridge: RTL and testbench

Byte-level I/O peripheral for the brainfuck core: the far end of the core's parallel `.`/`,` character interface. It buffers bytes emitted by `.` in a small TX FIFO and serializes them as UART 8N1. It deserializes incoming UART 8N1 frames and delivers each byte to the core as a one-cycle `receivingChar` pulse that a pending `,` consumes. It sits between the core and the board's UART pins, in the core's clock domain.

---
 rtl/bf_uart_bridge.sv | 172 +++++++++++++++++
 tb/tb_bf_uart_bridge.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/bf_uart_bridge.sv
// UART 8N1 bridge for the brainfuck core: TX FIFO + serializer, optional RX deserializer.
// The RX path is built only when BF_UART_RX_EN is defined; otherwise its outputs are tied low.
module bf_uart_bridge #(
  parameter int unsigned CLK_DIV = 868,
  parameter int unsigned FIFO_AW = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sendingChar,
  input  logic [7:0] sendedChar,
  output logic       receivingChar,
  output logic [7:0] receivedChar,
  output logic       uart_tx,
  input  logic       uart_rx,
  output logic       tx_overflow,
  output logic       rx_frame_err
);

  localparam int unsigned DEPTH   = 1 << FIFO_AW;
  localparam logic [15:0] DIV_M1  = 16'(CLK_DIV - 1);
  localparam logic [15:0] HALF_M1 = 16'(CLK_DIV / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_st_e;

  // ---------------- TX FIFO ----------------
  logic [7:0]       fifo_mem [DEPTH];
  logic [FIFO_AW:0] wr_ptr, rd_ptr;
  logic             fifo_empty, fifo_full, fifo_push, tx_pop;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                      (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
  assign fifo_push  = sendingChar && (!fifo_full || tx_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      tx_overflow <= 1'b0;
    end else begin
      if (fifo_push)                 wr_ptr      <= wr_ptr + (FIFO_AW+1)'(1);
      if (tx_pop)                    rd_ptr      <= rd_ptr + (FIFO_AW+1)'(1);
      if (sendingChar && !fifo_push) tx_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem[wr_ptr[FIFO_AW-1:0]] <= sendedChar;
  end

  // ---------------- TX serializer ----------------
  uart_st_e    tx_st, tx_st_n;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_sh;
  logic        tx_tick;

  assign tx_tick = (tx_cnt == DIV_M1);

  always_comb begin
    tx_st_n = tx_st;
    tx_pop  = 1'b0;
    case (tx_st)
      S_IDLE:  if (!fifo_empty) begin tx_pop = 1'b1; tx_st_n = S_START; end
      S_START: if (tx_tick) tx_st_n = S_DATA;
      S_DATA:  if (tx_tick && tx_bit == 3'd7) tx_st_n = S_STOP;
      S_STOP:  if (tx_tick) begin
                 if (!fifo_empty) begin tx_pop = 1'b1; tx_st_n = S_START; end
                 else tx_st_n = S_IDLE;
               end
      default: tx_st_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tx_st <= S_IDLE;
    else        tx_st <= tx_st_n;
  end

  // uart_tx is a registered view of the state, one cycle behind it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_cnt  <= '0;
      tx_bit  <= '0;
      tx_sh   <= '0;
      uart_tx <= 1'b1;
    end else begin
      tx_cnt <= (tx_st == S_IDLE || tx_tick) ? '0 : tx_cnt + 16'd1;
      if (tx_pop) begin
        tx_sh  <= fifo_mem[rd_ptr[FIFO_AW-1:0]];
        tx_bit <= '0;
      end else if (tx_st == S_DATA && tx_tick) begin
        tx_sh  <= {1'b0, tx_sh[7:1]};
        tx_bit <= tx_bit + 3'd1;
      end
      case (tx_st)
        S_START: uart_tx <= 1'b0;
        S_DATA:  uart_tx <= tx_sh[0];
        default: uart_tx <= 1'b1;
      endcase
    end
  end

  // ---------------- RX deserializer ----------------
`ifdef BF_UART_RX_EN
  logic [1:0]  rx_sync;
  logic        rx_s, rx_prev, rx_sample;
  uart_st_e    rx_st, rx_st_n;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_sh;

  assign rx_s      = rx_sync[1];
  assign rx_sample = (rx_st == S_START) ? (rx_cnt == HALF_M1) : (rx_cnt == DIV_M1);

  always_comb begin
    rx_st_n = rx_st;
    case (rx_st)
      S_IDLE:  if (rx_prev && !rx_s) rx_st_n = S_START;
      S_START: if (rx_sample) rx_st_n = rx_s ? S_IDLE : S_DATA;
      S_DATA:  if (rx_sample && rx_bit == 3'd7) rx_st_n = S_STOP;
      S_STOP:  if (rx_sample) rx_st_n = S_IDLE;
      default: rx_st_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rx_st <= S_IDLE;
    else        rx_st <= rx_st_n;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_sync       <= 2'b11;
      rx_prev       <= 1'b1;
      rx_cnt        <= '0;
      rx_bit        <= '0;
      rx_sh         <= '0;
      receivedChar  <= '0;
      receivingChar <= 1'b0;
      rx_frame_err  <= 1'b0;
    end else begin
      rx_sync       <= {rx_sync[0], uart_rx};
      rx_prev       <= rx_s;
      rx_cnt        <= (rx_st == S_IDLE || rx_sample) ? '0 : rx_cnt + 16'd1;
      receivingChar <= 1'b0;
      rx_frame_err  <= 1'b0;
      if (rx_st == S_START) rx_bit <= '0;
      if (rx_st == S_DATA && rx_sample) begin
        rx_sh  <= {rx_s, rx_sh[7:1]};
        rx_bit <= rx_bit + 3'd1;
      end
      if (rx_st == S_STOP && rx_sample) begin
        if (rx_s) begin
          receivedChar  <= rx_sh;
          receivingChar <= 1'b1;
        end else begin
          rx_frame_err  <= 1'b1;
        end
      end
    end
  end
`else
  logic unused_rx;
  assign unused_rx     = uart_rx;
  assign receivingChar = 1'b0;
  assign receivedChar  = 8'h00;
  assign rx_frame_err  = 1'b0;
`endif

endmodule

// File: tb/tb_bf_uart_bridge.sv
// Self-checking bench for bf_uart_bridge: a queue/timeline model of the TX line checked
// every cycle, plus directed and randomized RX frames when BF_UART_RX_EN is defined.
module tb_bf_uart_bridge;
  localparam int D     = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0, reset = 1'b0, sendingChar = 1'b0, uart_rx = 1'b1;
  logic [7:0] sendedChar = 8'h00;
  logic       receivingChar, uart_tx, tx_overflow, rx_frame_err;
  logic [7:0] receivedChar;

  int checks = 0, errors = 0, cyc = 0;

  always #5 clk = ~clk;

  bf_uart_bridge #(.CLK_DIV(D), .FIFO_AW(2)) dut (
    .clk(clk), .reset(reset), .sendingChar(sendingChar), .sendedChar(sendedChar),
    .receivingChar(receivingChar), .receivedChar(receivedChar), .uart_tx(uart_tx),
    .uart_rx(uart_rx), .tx_overflow(tx_overflow), .rx_frame_err(rx_frame_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // TX model: a queue of buffered bytes and a list of frames (line-low start cycle, byte).
  logic [7:0] mq[$];
  int         fs[$];
  logic [7:0] fb[$];
  bit         m_ovf = 1'b0;

  function automatic logic exp_tx_at(int c);
    exp_tx_at = 1'b1;
    foreach (fs[i]) begin
      if (c >= fs[i] && c < fs[i] + 10*D) begin
        int k;
        k = (c - fs[i]) / D;
        if (k == 0)      exp_tx_at = 1'b0;
        else if (k <= 8) exp_tx_at = fb[i][k-1];
      end
    end
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
      mq.delete(); fs.delete(); fb.delete(); m_ovf = 1'b0;
    end else begin
      // The line picks up a new byte one cycle before the previous stop bit ends,
      // or one cycle after it is pushed when the line is idle.
      if (mq.size() > 0 && (fs.size() == 0 || cyc >= fs[fs.size()-1] + 10*D - 1)) begin
        fs.push_back(cyc + 1);
        fb.push_back(mq.pop_front());
      end
      if (sendingChar) begin
        if (mq.size() < DEPTH) mq.push_back(sendedChar);
        else m_ovf = 1'b1;
      end
    end
    #1;
    check("uart_tx", uart_tx, exp_tx_at(cyc));
    check("tx_overflow", tx_overflow, m_ovf);
`ifndef BF_UART_RX_EN
    check("rx_tied_off", {rx_frame_err, receivingChar, receivedChar}, 0);
`endif
  end

  task automatic push(input logic [7:0] b);
    @(negedge clk); sendingChar = 1'b1; sendedChar = b;
    @(negedge clk); sendingChar = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b0;
    repeat (2) @(negedge clk); reset = 1'b1;
  endtask

`ifdef BF_UART_RX_EN
  int         n_rc = 0, n_fe = 0, rc_cyc = 0;
  logic [7:0] exp_rchar = 8'h00;

  always @(posedge clk) begin
    #1;
    if (receivingChar === 1'b1) begin n_rc++; rc_cyc = cyc; end
    if (rx_frame_err === 1'b1) n_fe++;
  end

  task automatic rx_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    int c0, n0, e0;
    f = {stop, b, 1'b0};
    n0 = n_rc; e0 = n_fe;
    @(negedge clk);
    c0 = cyc + 1;
    for (int i = 0; i < 10; i++) begin
      uart_rx = f[i];
      repeat (D) @(negedge clk);
    end
    uart_rx = 1'b1;
    repeat (8) @(negedge clk);
    if (stop) begin
      exp_rchar = b;
      check("rx_strobe_count", n_rc - n0, 1);
      check("rx_no_frame_err", n_fe - e0, 0);
      check("rx_latency_window", 32'((rc_cyc - c0 >= 39) && (rc_cyc - c0 <= 42)), 1);
    end else begin
      check("rx_bad_no_strobe", n_rc - n0, 0);
      check("rx_bad_frame_err", n_fe - e0, 1);
    end
    check("receivedChar", receivedChar, exp_rchar);
  endtask
`endif

  initial begin
    logic [9:0] pat;
    int n, lows;

    repeat (2) @(negedge clk);
    check("rst_uart_tx", uart_tx, 1);
    check("rst_tx_overflow", tx_overflow, 0);
    check("rst_receivingChar", receivingChar, 0);
    check("rst_receivedChar", receivedChar, 0);
    check("rst_rx_frame_err", rx_frame_err, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Single 0x41 from idle: start at push+2, LSB first.
    push(8'h41);
    n = cyc;
    @(posedge clk); #1;
    check("tx_high_at_push_plus1", uart_tx, 1);
    pat = 10'b1_0100_0001_0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      check("tx_0x41_waveform", uart_tx, pat[k/D]);
    end
    check("tx_0x41_no_overflow", tx_overflow, 0);
    check("model_first_start", fs[0], n + 2);
    repeat (4) @(negedge clk);

    // Burst of 6 into a 4-deep FIFO: one in flight, four buffered, sixth dropped.
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      if (i == 6) check("no_overflow_before_6th", tx_overflow, 0);
      push(8'(i));
      repeat (2) @(negedge clk);
    end
    check("overflow_after_6th", tx_overflow, 1);
    repeat (220) @(negedge clk);
    check("overflow_sticky", tx_overflow, 1);
    check("model_burst_frames", fs.size(), 5);
    for (int i = 0; i < 5; i++) check("model_burst_byte", fb[i], i + 1);
    check("model_burst_back_to_back", fs[4] - fs[0], 4*10*D);

    // Randomized pushes against the model.
    do_reset();
    for (int i = 0; i < 25; i++) begin
      push(8'($urandom_range(0, 255)));
      repeat ($urandom_range(2, 30)) @(negedge clk);
    end
    repeat (300) @(negedge clk);

`ifdef BF_UART_RX_EN
    rx_frame(8'h5B, 1'b1);
    rx_frame(8'hAA, 1'b0);
    rx_frame(8'h2B, 1'b1);
    n = n_rc;
    lows = n_fe;
    @(negedge clk); uart_rx = 1'b0;
    @(negedge clk); uart_rx = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_no_strobe", n_rc - n, 0);
    check("glitch_no_frame_err", n_fe - lows, 0);
    rx_frame(8'h3C, 1'b1);
    for (int i = 0; i < 4; i++) rx_frame(8'($urandom_range(0, 255)), 1'b1);
`endif

    // Reset mid-frame with three bytes queued.
    push(8'h00); repeat (2) @(negedge clk);
    push(8'h10); repeat (2) @(negedge clk);
    push(8'h20); repeat (2) @(negedge clk);
    push(8'h30);
    @(posedge clk); #3;
    check("tx_low_before_reset", uart_tx, 0);
    reset = 1'b0;
    #1;
    check("tx_high_on_async_reset", uart_tx, 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    lows = 0;
    repeat (100) begin
      @(posedge clk); #2;
      if (uart_tx !== 1'b1) lows++;
    end
    check("no_frames_after_reset", lows, 0);
    check("no_overflow_after_reset", tx_overflow, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
